// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, per-scan key capture, multi-scan debounce.
// Optional build macro KB_GHOST_REJECT_EN: any scan with two or more low columns reports no key.
module keypad_scanner #(
   parameter int SCAN_CYCLES    = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [4:0] kb_idx,
   output logic       key_pulse
);

   localparam int CW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_CYCLES - 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_SCANS);

   localparam logic [1:0] ST_IDLE        = 2'd0;
   localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
   localparam logic [1:0] ST_HELD        = 2'd2;
   localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

   function automatic logic [1:0] first_low(input logic [3:0] v);
      casez (v)
         4'b???1: return 2'd0;
         4'b??10: return 2'd1;
         4'b?100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
      case ({row, col})
         4'h0:    return 4'd1;
         4'h1:    return 4'd2;
         4'h2:    return 4'd3;
         4'h3:    return 4'd10;
         4'h4:    return 4'd4;
         4'h5:    return 4'd5;
         4'h6:    return 4'd6;
         4'h7:    return 4'd11;
         4'h8:    return 4'd7;
         4'h9:    return 4'd8;
         4'hA:    return 4'd9;
         4'hB:    return 4'd12;
         4'hC:    return 4'd14;
         4'hD:    return 4'd0;
         4'hE:    return 4'd15;
         4'hF:    return 4'd13;
         default: return 4'd0;
      endcase
   endfunction

`ifdef KB_GHOST_REJECT_EN
   function automatic logic multi_low(input logic [3:0] v);
      return ((v & (v - 4'd1)) != 4'd0);
   endfunction
`endif

   logic [CW-1:0] cyc_cnt_r;
   logic [1:0]    row_r;
   logic          acc_hit_r;
   logic [3:0]    acc_code_r;
   logic          scan_done_r;
   logic          scan_hit_r;
   logic [3:0]    scan_code_r;
   logic [1:0]    state_r;
   logic [DW-1:0] deb_cnt_r;
   logic [3:0]    cand_r;

   logic [3:0]    col_low_s;
   logic          prev_hit_s;
   logic [3:0]    prev_code_s;
   logic          next_hit_s;
   logic [3:0]    next_code_s;
   logic          scan_hit_s;
`ifdef KB_GHOST_REJECT_EN
   logic          acc_multi_r;
   logic          prev_multi_s;
   logic          next_multi_s;
`endif

   // Fold the current row's columns into the scan result; row 0 starts a fresh scan.
   always_comb begin
      col_low_s = ~col_in;
      if (row_r == 2'd0) begin
         prev_hit_s  = 1'b0;
         prev_code_s = 4'd0;
      end else begin
         prev_hit_s  = acc_hit_r;
         prev_code_s = acc_code_r;
      end
      if (!prev_hit_s && (col_low_s != 4'd0)) begin
         next_hit_s  = 1'b1;
         next_code_s = encode_key(row_r, first_low(col_low_s));
      end else begin
         next_hit_s  = prev_hit_s;
         next_code_s = prev_code_s;
      end
`ifdef KB_GHOST_REJECT_EN
      if (row_r == 2'd0) begin
         prev_multi_s = 1'b0;
      end else begin
         prev_multi_s = acc_multi_r;
      end
      next_multi_s = prev_multi_s | (prev_hit_s & (col_low_s != 4'd0)) | multi_low(col_low_s);
      scan_hit_s   = next_hit_s & ~next_multi_s;
`else
      scan_hit_s   = next_hit_s;
`endif
   end

   // Row strobe timing, column sampling at the end of each row slot, scan completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt_r   <= {CW{1'b0}};
         row_r       <= 2'd0;
         row_out     <= 4'b1110;
         acc_hit_r   <= 1'b0;
         acc_code_r  <= 4'd0;
         scan_done_r <= 1'b0;
         scan_hit_r  <= 1'b0;
         scan_code_r <= 4'd0;
`ifdef KB_GHOST_REJECT_EN
         acc_multi_r <= 1'b0;
`endif
      end else begin
         scan_done_r <= 1'b0;
         if (cyc_cnt_r == CYC_LAST) begin
            cyc_cnt_r  <= {CW{1'b0}};
            row_r      <= row_r + 2'd1;
            row_out    <= {row_out[2:0], row_out[3]};
            acc_hit_r  <= next_hit_s;
            acc_code_r <= next_code_s;
`ifdef KB_GHOST_REJECT_EN
            acc_multi_r <= next_multi_s;
`endif
            if (row_r == 2'd3) begin
               scan_done_r <= 1'b1;
               scan_hit_r  <= scan_hit_s;
               scan_code_r <= next_code_s;
            end
         end else begin
            cyc_cnt_r <= cyc_cnt_r + CW'(1);
         end
      end
   end

   // Debounce: accept after DEBOUNCE_SCANS identical hits, release after as many empty scans.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         deb_cnt_r <= {DW{1'b0}};
         cand_r    <= 4'd0;
         kb_idx    <= 5'd0;
         key_pulse <= 1'b0;
      end else begin
         key_pulse <= 1'b0;
         if (scan_done_r) begin
            case (state_r)
               ST_IDLE: begin
                  if (scan_hit_r) begin
                     cand_r    <= scan_code_r;
                     deb_cnt_r <= DW'(1);
                     if (DEB_MAX == DW'(1)) begin
                        state_r   <= ST_HELD;
                        kb_idx    <= {1'b1, scan_code_r};
                        key_pulse <= 1'b1;
                     end else begin
                        state_r <= ST_PRESS_CHK;
                     end
                  end
               end
               ST_PRESS_CHK: begin
                  if (!scan_hit_r) begin
                     state_r   <= ST_IDLE;
                     deb_cnt_r <= {DW{1'b0}};
                  end else if (scan_code_r == cand_r) begin
                     if ((deb_cnt_r + DW'(1)) >= DEB_MAX) begin
                        state_r   <= ST_HELD;
                        deb_cnt_r <= DEB_MAX;
                        kb_idx    <= {1'b1, cand_r};
                        key_pulse <= 1'b1;
                     end else begin
                        deb_cnt_r <= deb_cnt_r + DW'(1);
                     end
                  end else begin
                     cand_r    <= scan_code_r;
                     deb_cnt_r <= DW'(1);
                  end
               end
               ST_HELD: begin
                  if (!scan_hit_r && (DEB_MAX == DW'(1))) begin
                     state_r   <= ST_IDLE;
                     deb_cnt_r <= {DW{1'b0}};
                     kb_idx    <= {1'b0, kb_idx[3:0]};
                  end else if (!(scan_hit_r && (scan_code_r == cand_r))) begin
                     state_r   <= ST_RELEASE_CHK;
                     deb_cnt_r <= scan_hit_r ? {DW{1'b0}} : DW'(1);
                  end
               end
               ST_RELEASE_CHK: begin
                  if (scan_hit_r && (scan_code_r == cand_r)) begin
                     state_r   <= ST_HELD;
                     deb_cnt_r <= {DW{1'b0}};
                  end else if (scan_hit_r) begin
                     deb_cnt_r <= {DW{1'b0}};
                  end else if ((deb_cnt_r + DW'(1)) >= DEB_MAX) begin
                     state_r   <= ST_IDLE;
                     deb_cnt_r <= {DW{1'b0}};
                     kb_idx    <= {1'b0, kb_idx[3:0]};
                  end else begin
                     deb_cnt_r <= deb_cnt_r + DW'(1);
                  end
               end
               default: begin
                  state_r   <= ST_IDLE;
                  deb_cnt_r <= {DW{1'b0}};
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: an emulated keypad drives col_in, a run-length model predicts outputs.
module tb_keypad_scanner;

   localparam int SC       = 4;
   localparam int DS       = 2;
   localparam int SCAN_LEN = 4 * SC;

   typedef struct {
      int         cyc;
      logic [4:0] kb;
      logic       pulse;
   } ev_t;

   logic        clk;
   logic        rst;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [4:0]  kb_idx;
   logic        key_pulse;
   logic [15:0] pressed;

   int   total = 0;
   int   bad   = 0;
   int   cyc_t = 0;
   logic in_reset = 1'b1;
   ev_t  exp_q[$];

   // reference model state (per phase)
   logic       m_held;
   int         m_same_run;
   int         m_empty_run;
   logic       m_last_hit;
   logic [3:0] m_last_code;
   logic [4:0] m_kb;
   int         m_scan;

   // key code by bit index row*4+col
   logic [3:0] key_code [0:15] = '{4'd1, 4'd2, 4'd3, 4'd10,
                                   4'd4, 4'd5, 4'd6, 4'd11,
                                   4'd7, 4'd8, 4'd9, 4'd12,
                                   4'd14, 4'd0, 4'd15, 4'd13};

   keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DS)) dut (
      .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
      .kb_idx(kb_idx), .key_pulse(key_pulse));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // keypad matrix: a pressed key pulls its column low while its row is driven low
   always_comb begin
      col_in = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
   end

   always @(posedge clk) begin
      in_reset <= rst;
      if (rst) cyc_t <= 0;
      else     cyc_t <= cyc_t + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_held = 1'b0; m_same_run = 0; m_empty_run = 0;
      m_last_hit = 1'b0; m_last_code = 4'd0; m_kb = 5'd0; m_scan = 0;
   endtask

   task automatic model_scan(input logic [15:0] mask);
      int n; int first; logic hit; logic [3:0] code; ev_t ev;
      n = $countones(mask);
      first = 0;
      for (int i = 15; i >= 0; i--) if (mask[i]) first = i;
`ifdef KB_GHOST_REJECT_EN
      hit = (n == 1);
`else
      hit = (n >= 1);
`endif
      code = key_code[first];
      if (hit && m_last_hit && code == m_last_code) m_same_run = m_same_run + 1;
      else m_same_run = hit ? 1 : 0;
      if (!hit) m_empty_run = m_empty_run + 1;
      else m_empty_run = 0;
      m_last_hit = hit; m_last_code = code;
      ev.cyc = m_scan * SCAN_LEN + SCAN_LEN + 1;
      if (!m_held && hit && m_same_run == DS) begin
         m_held = 1'b1; m_kb = {1'b1, code};
         ev.kb = m_kb; ev.pulse = 1'b1; exp_q.push_back(ev);
      end else if (m_held && m_empty_run == DS) begin
         m_held = 1'b0; m_kb[4] = 1'b0;
         ev.kb = m_kb; ev.pulse = 1'b0; exp_q.push_back(ev);
      end
      m_scan = m_scan + 1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic run_scans(input logic [15:0] mask, input int n);
      for (int i = 0; i < n; i++) begin
         pressed = mask;
         model_scan(mask);
         repeat (SCAN_LEN) @(posedge clk);
         #1;
      end
   endtask

   task automatic finish_phase(input string name, input logic [4:0] exp_kb);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check({name, "_drained"}, exp_q.size(), 0);
      check({name, "_kb"}, kb_idx, exp_kb);
      @(posedge clk);
      #1;
   endtask

   // monitor: reset values, row walk, and scoreboard pops on every output event
   initial begin
      ev_t ev; logic [4:0] prev_kb; logic [3:0] exp_row;
      prev_kb = 5'd0;
      forever begin
         @(negedge clk);
         if (in_reset) begin
            check("rst_row_out", row_out, 4'b1110);
            check("rst_kb_idx", kb_idx, 5'd0);
            check("rst_key_pulse", key_pulse, 1'b0);
         end else begin
            exp_row = ~(4'b0001 << ((cyc_t / SC) % 4));
            check("row_walk", row_out, exp_row);
            if (key_pulse || kb_idx != prev_kb) begin
               if (exp_q.size() == 0) begin
                  total = total + 1; bad = bad + 1;
                  $display("FAIL unexpected_output kb_idx=%0h key_pulse=%b cycle=%0d expected no event",
                           kb_idx, key_pulse, cyc_t);
               end else begin
                  ev = exp_q.pop_front();
                  check("event_cycle", cyc_t, ev.cyc);
                  check("event_kb_idx", kb_idx, ev.kb);
                  check("event_key_pulse", key_pulse, ev.pulse);
               end
            end
         end
         prev_kb = kb_idx;
      end
   end

   initial begin
      logic [15:0] mask; int nseg;
      rst = 1'b1;
      pressed = 16'h0000;
      model_reset();

      // reset values and row walk with no key
      do_reset();
      run_scans(16'h0000, 2);
      finish_phase("idle", 5'h00);

      // "5" held 12 scans: one pulse, then quiet
      do_reset();
      run_scans(16'h0001 << 5, 12);
      finish_phase("key5", 5'h15);

      // "#" 2 scans then released 2 scans
      do_reset();
      run_scans(16'h0001 << 14, 2);
      run_scans(16'h0000, 2);
      finish_phase("hash_release", 5'h0F);

      // bounce on "A"
      do_reset();
      run_scans(16'h0001 << 3, 1);
      run_scans(16'h0000, 1);
      run_scans(16'h0001 << 3, 1);
      run_scans(16'h0000, 2);
      finish_phase("bounce", 5'h00);

      // "1" and "D" together
      do_reset();
      run_scans(16'h8001, 4);
`ifdef KB_GHOST_REJECT_EN
      finish_phase("two_keys", 5'h00);
`else
      finish_phase("two_keys", 5'h11);
`endif

      // reset in the middle of press checking on "*"
      do_reset();
      run_scans(16'h0001 << 12, 1);
      repeat (5) @(posedge clk);
      #1;
      do_reset();
      run_scans(16'h0001 << 12, 3);
      finish_phase("star_after_reset", 5'h1E);

      // random key sequences
      for (int p = 0; p < 25; p++) begin
         do_reset();
         nseg = $urandom_range(4, 10);
         for (int s = 0; s < nseg; s++) begin
            case ($urandom_range(0, 9))
               0, 1, 2:    mask = 16'h0000;
               8, 9:       mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
               default:    mask = 16'h0001 << $urandom_range(0, 15);
            endcase
            run_scans(mask, $urandom_range(1, 4));
         end
         finish_phase("random", m_kb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
